// File: rtl/agu_issue_buffer.sv
// agu_issue_buffer: two-entry FIFO between address calculation and execute.
// Define AGU_ISSUE_BYPASS_EN for a zero-latency path through the empty buffer.
module agu_issue_buffer #(
    parameter int PAYLOAD_W = 256,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 isAddressCalculationSuccessfulIn,
    input  logic [0:PAYLOAD_W-1] payloadIn,
    output logic                 canAddressCalculationOut,
    output logic                 executeValidOut,
    output logic [0:PAYLOAD_W-1] payloadOut,
    input  logic                 executeReadyIn,
    input  logic                 flushIn,
    output logic [1:0]           occupancyOut,
    output logic [31:0]          stallCountOut
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } bufState_e;

    generate
        if (DEPTH != 2) begin : gDepthCheck
            $error("agu_issue_buffer supports DEPTH == 2 only");
        end
    endgenerate

    bufState_e            state;
    bufState_e            nextState;
    logic [0:PAYLOAD_W-1] headReg;
    logic [0:PAYLOAD_W-1] tailReg;
    logic [31:0]          stallCount;

    logic enq;
    logic deq;
    logic headLoad;
    logic headFromTail;
    logic tailLoad;
    logic stallInc;

    always_comb begin
        nextState                = state;
        headLoad                 = 1'b0;
        headFromTail             = 1'b0;
        tailLoad                 = 1'b0;
        canAddressCalculationOut = (state != FULL);
`ifdef AGU_ISSUE_BYPASS_EN
        // Empty buffer passes the producer straight through to execute.
        if (state == EMPTY) begin
            executeValidOut = resetN && isAddressCalculationSuccessfulIn;
            payloadOut      = resetN ? payloadIn : '0;
        end else begin
            executeValidOut = 1'b1;
            payloadOut      = headReg;
        end
`else
        executeValidOut = (state != EMPTY);
        payloadOut      = (state != EMPTY) ? headReg : '0;
`endif
        enq      = isAddressCalculationSuccessfulIn && canAddressCalculationOut;
        deq      = executeValidOut && executeReadyIn;
        stallInc = executeValidOut && !executeReadyIn;

        if (flushIn) begin
            nextState = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (enq && !deq) begin
                        nextState = ONE;
                        headLoad  = 1'b1;
                    end
                end
                ONE: begin
                    unique case ({enq, deq})
                        2'b11: headLoad = 1'b1;
                        2'b10: begin
                            nextState = FULL;
                            tailLoad  = 1'b1;
                        end
                        2'b01: nextState = EMPTY;
                        default: nextState = ONE;
                    endcase
                end
                FULL: begin
                    if (deq) begin
                        nextState    = ONE;
                        headFromTail = 1'b1;
                    end
                end
                default: nextState = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= EMPTY;
            headReg    <= '0;
            tailReg    <= '0;
            stallCount <= '0;
        end else begin
            state <= nextState;
            if (headLoad) begin
                headReg <= payloadIn;
            end else if (headFromTail) begin
                headReg <= tailReg;
            end
            if (tailLoad) begin
                tailReg <= payloadIn;
            end
            // Saturating counter; flush deliberately leaves it alone.
            if (stallInc && (stallCount != 32'hFFFF_FFFF)) begin
                stallCount <= stallCount + 32'd1;
            end
        end
    end

    assign occupancyOut  = state;
    assign stallCountOut = stallCount;

endmodule
